// File: rtl/seq_alu_if.sv
// Operand/result bundle between the control unit (master) and seq_alu (slave).
// Start is a level request; busy/done are the completion handshake back.
interface seq_alu_if #(
   parameter int W = 32
);
   logic         start;
   logic [2:0]   cntl;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] out;
   logic         CO;
   logic         OVF;
   logic         N;
   logic         Z;
   logic         busy;
   logic         done;

   modport master (
      output start, cntl, A, B,
      input  out, CO, OVF, N, Z, busy, done
   );

   modport slave (
      input  start, cntl, A, B,
      output out, CO, OVF, N, Z, busy, done
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: logic/add/sub finish 1 cycle after start, shifts 1+shamt, multiply 1+W.
// Start is only taken in IDLE/DONE and dropped while busy; results hold until the next completion.
module seq_alu #(
   parameter int W = 32
) (
   input  logic     clk,
   input  logic     reset,
   seq_alu_if.slave bus
);
   localparam int SW = $clog2(W);
   localparam int CW = $clog2(W + 1);
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   if (W < 4 || W > 64) begin : g_bad_w
      $error("seq_alu: W must be in 4..64");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q;
   logic [2:0]     op_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   out_q;
   logic [2*W-1:0] acc_q;
   logic [CW-1:0]  cnt_q;
   logic           co_q, ovf_q, n_q, z_q, busy_q, done_q;

   logic [W:0]     sum_d, dif_d;
   logic [W-1:0]   alu_d;
   logic           alu_co_d, alu_ovf_d;
   logic [CW-1:0]  shamt_d;

   always_comb begin
      sum_d     = {1'b0, bus.A} + {1'b0, bus.B};
      dif_d     = {1'b0, bus.A} - {1'b0, bus.B};
      shamt_d   = CW'(bus.B[SW-1:0]);
      alu_d     = bus.A;
      alu_co_d  = 1'b0;
      alu_ovf_d = 1'b0;
      case (bus.cntl)
         3'b000: begin
            alu_d     = sum_d[W-1:0];
            alu_co_d  = sum_d[W];
            alu_ovf_d = (bus.A[W-1] == bus.B[W-1]) && (sum_d[W-1] != bus.A[W-1]);
         end
         3'b001: begin
            alu_d     = dif_d[W-1:0];
            alu_co_d  = dif_d[W];
            alu_ovf_d = (bus.A[W-1] != bus.B[W-1]) && (dif_d[W-1] == bus.B[W-1]);
         end
         3'b010:  alu_d = bus.A & bus.B;
         3'b011:  alu_d = bus.A | bus.B;
         3'b100:  alu_d = bus.A ^ bus.B;
         // zero-count shifts complete immediately with A unchanged
         default: alu_d = bus.A;
      endcase
   end

   logic [W:0]     mul_hi_d;
   logic [2*W-1:0] acc_d;
   logic [W-1:0]   shf_d, fin_d;
   logic           shf_co_d, fin_co_d;

   // acc holds {partial product, remaining multiplier bits}; add A into the top half, then shift right
   always_comb begin
      mul_hi_d = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
      acc_d    = {mul_hi_d, acc_q[W-1:1]};
      shf_d    = (op_q == OP_SRL) ? (a_q >> 1) : (a_q << 1);
      shf_co_d = (op_q == OP_SRL) ? a_q[0] : a_q[W-1];
      fin_d    = (op_q == OP_MUL) ? acc_d[W-1:0] : shf_d;
      fin_co_d = (op_q == OP_MUL) ? (|acc_d[2*W-1:W]) : shf_co_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         out_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               cnt_q <= cnt_q - CW'(1);
               if (op_q == OP_MUL) acc_q <= acc_d;
               else                a_q   <= shf_d;
               if (cnt_q == CW'(1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  out_q   <= fin_d;
                  co_q    <= fin_co_d;
                  ovf_q   <= 1'b0;
                  n_q     <= fin_d[W-1];
                  z_q     <= (fin_d == '0);
               end
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
               if (bus.start) begin
                  op_q <= bus.cntl;
                  a_q  <= bus.A;
                  if (bus.cntl == OP_MUL) begin
                     acc_q   <= {{W{1'b0}}, bus.B};
                     cnt_q   <= CW'(W);
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end else if ((bus.cntl == OP_SLL || bus.cntl == OP_SRL) && shamt_d != '0) begin
                     cnt_q   <= shamt_d;
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     out_q   <= alu_d;
                     co_q    <= alu_co_d;
                     ovf_q   <= alu_ovf_d;
                     n_q     <= alu_d[W-1];
                     z_q     <= (alu_d == '0);
                  end
               end
            end
         endcase
      end
   end

   assign bus.out  = out_q;
   assign bus.CO   = co_q;
   assign bus.OVF  = ovf_q;
   assign bus.N    = n_q;
   assign bus.Z    = z_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised ALU for the single-cycle CPU datapath's next revision. It keeps the existing four operations (add, subtract, AND, OR) and their N/Z/CO/OVF flag semantics. It adds XOR, iterative logical shifts and an iterative unsigned multiply, all behind a start/busy/done handshake. Result and flags are registered and hold their values between operations, so the control unit can stall on `busy` and sample on `done`.

## Interface
- `W`, default 32: operand/result width; legal values 4..64.
- Derived `SW = $clog2(W)`: shift-amount width; only `B[SW-1:0]` is used for shifts.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request an operation; sampled only in IDLE or DONE.
- `cntl`, input, 3: opcode, sampled with `start`.
  - 000 add
  - 001 sub (A−B)
  - 010 and
  - 011 or
  - 100 xor
  - 101 sll
  - 110 srl
  - 111 mul (unsigned, low W bits)
- `A`, input, W: operand A, sampled with `start`.
- `B`, input, W: operand B or shift amount, sampled with `start`.
- `out`, output, W: registered result.
- `CO`, `OVF`, `N`, `Z`, outputs, 1 each: registered flags.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: high for exactly one cycle (the DONE state).

## Operation
- States: IDLE, RUN, DONE.
- `start` is accepted in IDLE or DONE; it is ignored in RUN, with no queuing and no effect.
- On acceptance, `A`, `B` and `cntl` are captured into internal registers, so later input changes have no effect.
- Single-cycle ops (000–100): next state DONE; result and flags written on the same edge.
- Shifts (101, 110):
  - Counter loaded with `B[SW-1:0]`.
  - If the count is 0, go to DONE with `out = A` and `CO = 0`.
  - Otherwise go to RUN and shift one bit per cycle, decrementing the counter; go to DONE when it reaches 0.
  - `CO` is the last bit shifted out.
- Multiply (111):
  - RUN for exactly W cycles, shift-add over a 2W-bit accumulator, one multiplier bit per cycle.
  - `out` is the low W bits.
  - `CO = 1` iff the high W bits are non-zero (unsigned overflow).
- DONE lasts one cycle. Without `start` it returns to IDLE; with `start` it accepts the new operation (back-to-back).
- Flag rules:
  - add: `{CO,out} = A+B`. `OVF = 1` when the operand signs are equal and the result sign differs.
  - sub: `{CO,out} = {1'b0,A} − {1'b0,B}`, so `CO` is the borrow. `OVF = 1` when the operand signs differ and the result sign equals B's sign.
  - and/or/xor/shift/mul: `OVF = 0`.
  - and/or/xor: `CO = 0`.
  - All ops: `N = out[W-1]`, `Z = (out == 0)`.
- `out` and all flags change only on the edge entering DONE, and hold until the next completion.
- An illegal W is a configuration error, checked by an elaboration-time assertion.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state IDLE
  - `out = 0`, `CO = OVF = N = Z = 0`
  - `busy = 0`, `done = 0`
  - counter and accumulator cleared
- Reset mid-RUN aborts the operation with no `done` pulse. The first `start` after `reset` deasserts is accepted normally.
- Latency from the `start` edge (T) to `done` high:
  - ops 000–100: T+1
  - shift: T+1+shamt
  - mul: T+1+W
- `busy` is high from T+1 through the last RUN cycle, never simultaneously with `done`. It stays 0 for single-cycle ops and for shamt = 0.
- Throughput: one operation every latency cycles when `start` is held high across DONE.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → all outputs 0 immediately. After release, with `start` = 0 → `busy` = 0 and `done` = 0 indefinitely.
- Add/sub (W=32):
  - 0x7FFFFFFF + 1 → `out` 0x80000000, N=1, OVF=1, CO=0, Z=0; `done` at T+1.
  - 5 − 5 → `out` 0, Z=1, CO=0.
  - 0 − 1 → `out` 0xFFFFFFFF, CO=1, N=1, OVF=0.
- Logic/shift:
  - 0xF0F0F0F0 xor 0xFFFFFFFF → 0x0F0F0F0F, CO=0.
  - sll A=0x80000001, B=4 → `busy` for 4 cycles, `done` at T+5, `out` 0x00000010, CO=0.
  - srl A=0x3, B=1 → `out` 0x1, CO=1.
  - sll with B=32 (shamt 0) → `out` = A, `done` at T+1.
- Multiply:
  - 7 × 6 → `out` 42, CO=0, `done` at T+33.
  - 0x00010000 × 0x00010000 → `out` 0, Z=1, CO=1.
- Handshake:
  - `start` pulsed at T+5 during a multiply → ignored, single `done` at T+33.
  - `start` held across DONE → next op accepted; its `done` occurs at its own latency after the DONE cycle.
- Reset mid-multiply at T+10 → no `done`, outputs 0. A subsequent add of 2 + 3 returns 5 at latency 1.
